// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per clock, LSB first.
// A start in IDLE captures the operands. RUN processes WIDTH bits. DONE emits a
// one-cycle done pulse and returns to IDLE. diff and bout hold until the next
// operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    // a_q doubles as the result shift register. Each RUN cycle consumes a_q[0]
    // and pushes the difference bit in at the MSB. After WIDTH shifts it holds
    // the full result.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic ai, bi, d_bit, br_next;

    // Full-subtractor cell acting on the current LSBs and the running borrow.
    assign ai      = a_q[0];
    assign bi      = b_q[0];
    assign d_bit   = ai ^ bi ^ br_q;
    assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);

    // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case. That way no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d    = {d_bit, a_q[WIDTH-1:1]};
                b_d    = {1'b0, b_q[WIDTH-1:1]};
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {d_bit, a_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // values, independent of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=2.
// Directed table, held-start, mid-RUN reset and random operations are compared
// against an arithmetic reference model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bout8;
    logic [7:0] diff8;

    logic       start2 = 1'b0, bin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, bout2;
    logic [1:0] diff2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    typedef struct {
        int         sel;       // 0: WIDTH=8 instance, 1: WIDTH=2 instance
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] exp_diff;
        logic       exp_bout;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: modular difference and unsigned comparison.
    function automatic logic [8:0] ref_sub(input int w, input int a, input int b, input int bin);
        int m;
        int r;
        logic [8:0] res;
        m   = 1 << w;
        r   = a - b - bin;
        r   = (r + m) % m;
        res = {(a < b + bin) ? 1'b1 : 1'b0, 8'(r)};
        return res;
    endfunction

    task automatic drive(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic st);
        if (sel == 0) begin
            a8 = a; b8 = b; bin8 = bin; start8 = st;
        end else begin
            a2 = a[1:0]; b2 = b[1:0]; bin2 = bin; start2 = st;
        end
    endtask

    task automatic sample(input int sel, output logic bs, output logic dn,
                          output logic [7:0] d, output logic bo);
        if (sel == 0) begin
            bs = busy8; dn = done8; d = diff8; bo = bout8;
        end else begin
            bs = busy2; dn = done2; d = {6'b0, diff2}; bo = bout2;
        end
    endtask

    // One full operation from IDLE. Operands are scrambled after capture.
    // Returns the latency in edges after the capture edge and the busy cycle count.
    // Ends one edge after done, back in IDLE.
    task automatic do_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic bin, output logic [7:0] d, output logic bo,
                         output int lat, output int bcnt);
        logic bs, dn, seen;
        logic [7:0] sd;
        logic sbo;
        @(negedge clk);
        drive(sel, a, b, bin, 1'b1);
        @(posedge clk);
        #1;
        drive(sel, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        seen = 1'b0; lat = -1; bcnt = 0; d = '0; bo = 1'b0;
        for (int j = 0; j <= 40 && !seen; j++) begin
            sample(sel, bs, dn, sd, sbo);
            if (dn) begin
                seen = 1'b1; lat = j; d = sd; bo = sbo;
            end else begin
                bcnt += int'(bs);
                @(negedge clk);
                drive(sel, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
                @(posedge clk);
                #1;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        sample(sel, bs, dn, sd, sbo);
        check("done_single_cycle", 32'(dn), 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        logic [7:0] d;
        logic       bo, bs, dn;
        logic [7:0] sd;
        logic       sbo;
        logic [8:0] r;
        logic [7:0] ha[3], hb[3];
        logic       hbin[3];
        int lat, bcnt, pulses, busy_seen, w, op;
        logic [7:0] ra, rb, mask;
        logic       rbin;

        vecs[0]  = '{0, 8'h50, 8'h20, 1'b0, 8'h30, 1'b0};
        vecs[1]  = '{0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2]  = '{0, 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1};
        vecs[3]  = '{0, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
        vecs[4]  = '{0, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
        vecs[5]  = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[6]  = '{0, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0};
        vecs[7]  = '{1, 8'h03, 8'h00, 1'b0, 8'h03, 1'b0};
        vecs[8]  = '{1, 8'h00, 8'h03, 1'b1, 8'h00, 1'b1};
        vecs[9]  = '{1, 8'h01, 8'h02, 1'b0, 8'h03, 1'b1};
        vecs[10] = '{1, 8'h02, 8'h01, 1'b1, 8'h00, 1'b0};

        // Reset values, asserted from time zero.
        #2;
        check("rst_busy8", 32'(busy8), 0);
        check("rst_done8", 32'(done8), 0);
        check("rst_diff8", 32'(diff8), 0);
        check("rst_bout8", 32'(bout8), 0);
        check("rst_busy2", 32'(busy2), 0);
        check("rst_diff2", 32'(diff2), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            w = (vecs[i].sel == 0) ? 8 : 2;
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, lat, bcnt);
            check($sformatf("vec%0d_diff", i), 32'(d), 32'(vecs[i].exp_diff));
            check($sformatf("vec%0d_bout", i), 32'(bo), 32'(vecs[i].exp_bout));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(w));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(w));
            repeat (3) @(posedge clk);
            #1;
            sample(vecs[i].sel, bs, dn, sd, sbo);
            check($sformatf("vec%0d_diff_hold", i), 32'(sd), 32'(vecs[i].exp_diff));
        end

        // Start held high: three back-to-back operations, garbage operands between captures.
        ha[0] = 8'h9A; hb[0] = 8'h35; hbin[0] = 1'b1;
        ha[1] = 8'h12; hb[1] = 8'h34; hbin[1] = 1'b0;
        ha[2] = 8'hC8; hb[2] = 8'h07; hbin[2] = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (j % 10 == 0) drive(0, ha[j/10], hb[j/10], hbin[j/10], 1'b1);
            else drive(0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            @(posedge clk);
            #1;
            if (j >= 8 && (j - 8) % 10 == 0) begin
                op = (j - 8) / 10;
                r  = ref_sub(8, int'(ha[op]), int'(hb[op]), int'(hbin[op]));
                check($sformatf("held%0d_done", op), 32'(done8), 32'd1);
                check($sformatf("held%0d_diff", op), 32'(diff8), 32'(r[7:0]));
                check($sformatf("held%0d_bout", op), 32'(bout8), 32'(r[8]));
            end else begin
                check($sformatf("held_nodone_e%0d", j), 32'(done8), 32'd0);
            end
        end
        @(negedge clk);
        drive(0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk);

        // Reset between edges in the 3rd RUN cycle.
        @(negedge clk);
        drive(0, 8'h77, 8'h11, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        r = ref_sub(8, 'hC8, 'h07, 1);
        check("pre_rst_diff_held", 32'(diff8), 32'(r[7:0]));
        check("pre_rst_busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", 32'(busy8), 0);
        check("midrun_rst_done", 32'(done8), 0);
        check("midrun_rst_diff", 32'(diff8), 0);
        check("midrun_rst_bout", 32'(bout8), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0; busy_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            pulses    += int'(done8);
            busy_seen += int'(busy8);
        end
        check("post_rst_done_pulses", 32'(pulses), 0);
        check("post_rst_busy_cycles", 32'(busy_seen), 0);
        do_op(0, 8'h50, 8'h20, 1'b0, d, bo, lat, bcnt);
        check("post_rst_op_diff", 32'(d), 32'h30);
        check("post_rst_op_latency", 32'(lat), 32'd8);

        // Random operations against the reference model at both widths.
        for (int sel = 0; sel < 2; sel++) begin
            w    = (sel == 0) ? 8 : 2;
            mask = (sel == 0) ? 8'hFF : 8'h03;
            for (int k = 0; k < 1000; k++) begin
                ra   = 8'($urandom) & mask;
                rb   = 8'($urandom) & mask;
                rbin = 1'($urandom);
                r    = ref_sub(w, int'(ra), int'(rb), int'(rbin));
                do_op(sel, ra, rb, rbin, d, bo, lat, bcnt);
                check($sformatf("rnd_w%0d_diff a=%0h b=%0h bin=%0b", w, ra, rb, rbin),
                      32'(d), 32'(r[7:0]));
                check($sformatf("rnd_w%0d_bout a=%0h b=%0h bin=%0b", w, ra, rb, rbin),
                      32'(bo), 32'(r[8]));
                check($sformatf("rnd_w%0d_latency", w), 32'(lat), 32'(w));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the operand and result width in bits; legal range is WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge only.
REQ-003 The block SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, request to begin one subtraction.
REQ-005 The block SHALL have port a, input, WIDTH, the minuend.
REQ-006 The block SHALL have port b, input, WIDTH, the subtrahend.
REQ-007 The block SHALL have port bin, input, 1, the borrow-in.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 The block SHALL have port diff, output, WIDTH, the registered difference.
REQ-011 The block SHALL have port bout, output, 1, the registered final borrow-out.

Function
REQ-012 The block SHALL implement an FSM with exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, on a clock edge with start=1, the block SHALL capture a, b and bin into internal registers, clear the bit counter and go to RUN.
REQ-014 In IDLE with start=0, the block SHALL stay in IDLE and hold diff and bout.
REQ-015 In RUN, the block SHALL process one bit per edge, LSB first, using a full-subtractor cell: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-016 The borrow register br SHALL be initialised from the captured bin and SHALL carry from bit i to bit i+1.
REQ-017 RUN SHALL last exactly WIDTH edges; on the WIDTH-th edge, diff SHALL load the assembled result, bout SHALL load the final br, and the FSM SHALL go to DONE.
REQ-018 In DONE, done SHALL be 1 for that single cycle, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-019 Latency: if start is sampled at edge t0, done SHALL be high in the cycle following edge t0+WIDTH.
REQ-020 With start held high continuously, a new operation SHALL be accepted every WIDTH+2 cycles.
REQ-021 busy SHALL be 1 exactly when the state is RUN.
REQ-022 done and busy SHALL be registered outputs, with no combinational path from any input.
REQ-023 Arithmetic: diff SHALL equal (a - b - bin) mod 2^WIDTH, and bout SHALL be 1 if and only if a < b + bin (unsigned).
REQ-024 start SHALL be ignored in RUN and DONE, and changes to a, b or bin after capture SHALL have no effect on the result in flight.
REQ-025 diff and bout SHALL change only on the DONE-entry edge and SHALL hold their values through IDLE until the next completion.
REQ-026 The all-ones boundary SHALL hold: a=0, b=2^WIDTH-1, bin=1 gives diff=0 and bout=1, with no overflow of internal width.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE and busy=0, done=0, diff=0, bout=0, and clear br, the counter and the operand registers.
REQ-028 Reset asserted mid-RUN SHALL abort the operation, and no done pulse SHALL follow reset release.
REQ-029 After rst_n rises, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-030 The bench SHALL cover these directed scenarios with WIDTH=8:
- a=0x50, b=0x20, bin=0, start pulse at edge t0 -> done high after edge t0+8, diff=0x30, bout=0; busy high for exactly 8 cycles.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
- a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1.
- a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1.
- start held high with a new (a, b) each operation -> done pulses spaced 10 cycles apart, each result matching its own captured operands; operand changes mid-RUN are ignored.
- rst_n driven low during the 3rd RUN cycle, between edges -> busy, done, diff and bout go to 0 at once; after release and 20 idle cycles, done never pulses.
REQ-031 The bench SHALL also run random (a, b, bin) against the REQ-023 reference model for at least 1000 operations at both WIDTH=8 and WIDTH=2.
